fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter Isize, 32, instruction/address width in bits.
REQ-002 Parameter RESET_PC, 0, byte address fetched first after reset.
REQ-003 Parameter HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_address  output  Isize  byte address presented to the instruction memory; equals PC combinationally.
REQ-007 imem_instruction  input  Isize  combinational read data for imem_address, valid in the same cycle.
REQ-008 redirect  input  1  branch/jump taken; flushes the fetch stream.
REQ-009 redirect_pc  input  Isize  new fetch byte address when redirect=1.
REQ-010 out_valid  output  1  out_instr/out_pc hold a valid fetched entry.
REQ-011 out_ready  input  1  decode stage accepts the entry this cycle.
REQ-012 out_instr  output  Isize  instruction at head of buffer.
REQ-013 out_pc  output  Isize  byte address of out_instr.
REQ-014 halted  output  1  unit is in HALTED state.

Function
REQ-015 Block SHALL hold PC register, 2-entry FIFO of {instr, pc}, 2-bit count, state in {RUN, HALTED}.
REQ-016 imem_address SHALL equal PC with bits [1:0] always 0.
REQ-017 Push: in RUN with count<2 and redirect=0, SHALL write {imem_instruction, PC} to FIFO tail and set PC <= PC+4 (mod 2^Isize, wrap to 0).
REQ-018 Pop: when out_valid=1 and out_ready=1 and redirect=0, head SHALL be removed at the clock edge.
REQ-019 Push eligibility SHALL use count at cycle start; when count==2, no push even if a pop occurs that cycle.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-021 out_valid SHALL equal (count!=0); out_instr/out_pc SHALL be the head entry, held stable while out_valid=1 and out_ready=0.
REQ-022 Fetch latency: instruction at PC SHALL appear on out_instr one cycle after it is pushed (registered output, no combinational path imem_instruction -> out_instr).
REQ-023 If a pushed instruction equals HALT_WORD, it SHALL still be pushed, PC SHALL NOT advance, and state SHALL become HALTED next cycle.
REQ-024 In HALTED, no push SHALL occur; pops SHALL continue until FIFO drains; halted=1.
REQ-025 redirect=1 (any state) SHALL have priority: FIFO emptied (count<=0), PC <= {redirect_pc[Isize-1:2], 2'b00}, state <= RUN; no push and no pop that cycle.
REQ-026 out_valid SHALL be 0 in the cycle after a redirect; first post-redirect instruction SHALL appear two cycles after redirect assertion.
REQ-027 FIFO pointers SHALL wrap modulo 2; count SHALL never exceed 2 or underflow below 0.

Reset
REQ-028 reset=1 at an edge SHALL set PC<=RESET_PC, count<=0, pointers<=0, state<=RUN; reset SHALL override redirect, push, pop.
REQ-029 After reset: out_valid=0, halted=0, imem_address=RESET_PC; out_instr/out_pc SHALL read 0.
REQ-030 Reset asserted mid-stream SHALL discard all buffered entries with no entry emitted afterwards.

Verification
REQ-031 Streaming: memory holds words 0x11,0x22,0x33 at 0,4,8; out_ready=1 -> out (pc,instr) = (0,0x11),(4,0x22),(8,0x33) on consecutive cycles starting cycle 2 after reset release.
REQ-032 Backpressure: out_ready=0 for 5 cycles -> count reaches 2, PC stops at 8, out holds (0,0x11); on out_ready=1 entries drain in order with no loss or duplicate.
REQ-033 Redirect: redirect=1, redirect_pc=0x103 while count=2 -> next cycle out_valid=0, imem_address=0x100; cycle after, out_pc=0x100.
REQ-034 Halt: word at 0xC = 32'hFFFF_FFFF -> pushed and emitted, halted=1, imem_address stays 0xC, no further pushes; redirect to 0x0 resumes RUN.
REQ-035 Wrap: RESET_PC=32'hFFFF_FFFC -> after first push imem_address=0x0.
REQ-036 Reset mid-run with count=2 and out_ready=0 -> next cycle out_valid=0, imem_address=RESET_PC, halted=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Keeps a word-aligned PC, reads the instruction memory at that PC, and buffers
// up to two {instr, pc} entries for the decode stage. A fetched HALT_WORD is
// buffered, PC stays on it, and fetching stops until a redirect. A redirect
// flushes the buffer and restarts fetching at the new aligned address.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   imem_address      : byte address to instruction memory (PC, low bits zero)
//   imem_instruction  : combinational read data for imem_address
//   redirect          : branch/jump taken, flush and refetch
//   redirect_pc       : new fetch byte address when redirect=1
//   out_valid         : head entry valid
//   out_ready         : decode accepts the head entry this cycle
//   out_instr, out_pc : head entry instruction and byte address
//   halted            : unit is in HALTED state
module fetch_unit #(
  parameter int unsigned       Isize     = 32,
  parameter logic [Isize-1:0]  RESET_PC  = '0,
  parameter logic [Isize-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  output logic [Isize-1:0] imem_address,
  input  logic [Isize-1:0] imem_instruction,
  input  logic             redirect,
  input  logic [Isize-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Isize-1:0] out_instr,
  output logic [Isize-1:0] out_pc,
  output logic             halted
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  // PC is held as a word index; the byte offset bits are always zero.
  logic [Isize-3:0] pc_word;
  logic [0:0]       state;
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [Isize-1:0] fifo_instr [2];
  logic [Isize-1:0] fifo_pc    [2];

  logic push;
  logic pop;
  logic is_halt;
  logic unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  assign imem_address = {pc_word, 2'b00};
  assign is_halt      = (imem_instruction == HALT_WORD);

  // Push eligibility looks at the count at cycle start, so a full buffer
  // does not accept a new entry even when the head leaves this cycle.
  assign push = (state == RUN) && (count != 2'd2) && !redirect;
  assign pop  = (count != 2'd0) && out_ready && !redirect;

  assign out_valid = (count != 2'd0);
  assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
  assign halted    = (state == HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_word <= RESET_PC[Isize-1:2];
      state   <= RUN;
      count   <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redirect) begin
      pc_word <= redirect_pc[Isize-1:2];
      state   <= RUN;
      count   <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push) begin
        fifo_instr[wr_ptr] <= imem_instruction;
        fifo_pc[wr_ptr]    <= {pc_word, 2'b00};
        wr_ptr             <= ~wr_ptr;
        if (is_halt) begin
          state <= HALTED;
        end else begin
          pc_word <= pc_word + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all checked against a queue-based reference model of the fetch
// buffer. A second instance with RESET_PC at the top of the address space
// checks PC wrap-around.
module tb_fetch_unit;

  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic        w_redirect = 1'b0;
  logic [31:0] w_rpc = '0;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic        w_halted;

  logic [31:0] mem [64];

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_halt;

  always #5 clk = ~clk;

  assign imem_instruction = mem[imem_address[7:2]];
  assign w_instr          = {w_addr[15:0], 16'h1234};

  fetch_unit #(.Isize(32), .RESET_PC(32'h0), .HALT_WORD(HALTW)) dut (
    .clk(clk), .reset(reset), .imem_address(imem_address),
    .imem_instruction(imem_instruction), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
  );

  fetch_unit #(.Isize(32), .RESET_PC(32'hFFFF_FFFC), .HALT_WORD(HALTW)) u_wrap (
    .clk(clk), .reset(reset), .imem_address(w_addr),
    .imem_instruction(w_instr), .redirect(w_redirect),
    .redirect_pc(w_rpc), .out_valid(w_valid), .out_ready(w_ready),
    .out_instr(w_out_instr), .out_pc(w_out_pc), .halted(w_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  task automatic model_reset(input logic [31:0] start);
    q.delete();
    m_pc   = start & 32'hFFFF_FFFC;
    m_halt = 1'b0;
  endtask

  // Apply inputs, check the current outputs against the model, advance the
  // model by one clock, then move to just after the next rising edge.
  task automatic step(input bit rst, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          can_push;
    logic [31:0] word;
    ent_t        e;
    reset = rst; redirect = rd; redirect_pc = rpc; out_ready = rdy;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("out_instr", out_instr, (q.size() != 0) ? q[0].instr : 32'h0);
    chk("out_pc", out_pc, (q.size() != 0) ? q[0].pc : 32'h0);
    chk("imem_address", imem_address, m_pc);
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    if (rst) begin
      model_reset(32'h0);
    end else if (rd) begin
      model_reset(rpc);
    end else begin
      can_push = !m_halt && (q.size() < 2);
      word     = mem_word(m_pc);
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (can_push) begin
        e.instr = word;
        e.pc    = m_pc;
        q.push_back(e);
        if (word == HALTW) m_halt = 1'b1;
        else               m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = HALTW;

    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    model_reset(32'h0);
    chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
    chk("rst_out_instr", out_instr, 32'h0);

    // Streaming into the halt word at 0xC.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_out_pc", w_out_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("halt_addr", imem_address, 32'hC);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_drained", {31'b0, out_valid}, 32'h0);

    // Redirect to 0 resumes fetching.
    step(1'b0, 1'b1, 32'h0, 1'b1);
    chk("resume_run", {31'b0, halted}, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure: buffer fills, PC stops at 8, head held.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("bp_addr", imem_address, 32'h8);
    chk("bp_pc", out_pc, 32'h0);
    chk("bp_instr", out_instr, 32'h11);

    // Redirect while full.
    step(1'b0, 1'b1, 32'h103, 1'b0);
    chk("redir_valid", {31'b0, out_valid}, 32'h0);
    chk("redir_addr", imem_address, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_out_pc", out_pc, 32'h100);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-run while full.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_addr", imem_address, 32'h0);
    chk("mid_rst_halted", {31'b0, halted}, 32'h0);

    // Random traffic with occasional halt words, redirects and resets.
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? HALTW : $urandom;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           $urandom, ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
